// File: rtl/input_cond_pkg.sv
// Shared types and helpers for the input conditioner.
package input_cond_pkg;

  typedef enum logic [1:0] {HOLD_IDLE, HOLD_PRESSED, HOLD_HELD} hold_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// One conditioner channel: synchroniser chain, tick-qualified debounce,
// press/release edge pulses and long-hold detection.
module input_conditioner_ch
  import input_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned HOLD_TICKS     = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic n_in_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic held_o,
  output logic hold_pulse_o
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_TICKS);
  localparam int unsigned HW = cnt_width(HOLD_TICKS);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic [HW-1:0]          hcnt_q, hcnt_d;
  hold_state_t            state_q, state_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic held_q, held_d;
  logic hold_pulse_q, hold_pulse_d;
  logic s;

  assign s = sync_q[SYNC_STAGES-1];

  // Next-state: sync shift, debounce counter, then hold FSM driven by the debounce events.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], n_in_i};
    dcnt_d       = dcnt_q;
    level_d      = level_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    held_d       = held_q;
    hold_pulse_d = 1'b0;

    if (s == level_q) begin
      dcnt_d = '0;
    end else if (tick_i) begin
      if (dcnt_q == DW'(DEBOUNCE_TICKS - 1)) begin
        level_d   = s;
        dcnt_d    = '0;
        press_d   = ~s;
        release_d = s;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end

    case (state_q)
      HOLD_IDLE: begin
        if (press_d) begin
          state_d = HOLD_PRESSED;
          hcnt_d  = '0;
        end
      end
      HOLD_PRESSED: begin
        if (release_d) begin
          state_d = HOLD_IDLE;
          hcnt_d  = '0;
          held_d  = 1'b0;
        end else if (tick_i) begin
          if (hcnt_q == HW'(HOLD_TICKS - 1)) begin
            state_d      = HOLD_HELD;
            hcnt_d       = HW'(HOLD_TICKS);
            held_d       = 1'b1;
            hold_pulse_d = 1'b1;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
      end
      HOLD_HELD: begin
        if (release_d) begin
          state_d = HOLD_IDLE;
          hcnt_d  = '0;
          held_d  = 1'b0;
        end
      end
      default: begin
        state_d = HOLD_IDLE;
        hcnt_d  = '0;
        held_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '1;
      dcnt_q       <= '0;
      hcnt_q       <= '0;
      state_q      <= HOLD_IDLE;
      level_q      <= 1'b1;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      held_q       <= 1'b0;
      hold_pulse_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      dcnt_q       <= dcnt_d;
      hcnt_q       <= hcnt_d;
      state_q      <= state_d;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      held_q       <= held_d;
      hold_pulse_q <= hold_pulse_d;
    end
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign held_o       = held_q;
  assign hold_pulse_o = hold_pulse_q;

endmodule

// File: rtl/input_conditioner.sv
// Per-channel conditioning of active-low pad inputs: sync, debounce,
// press/release pulses and long-hold detection.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned HOLD_TICKS     = 1000
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              Tick,
  input  logic [NUM_CH-1:0] nIn,
  output logic [NUM_CH-1:0] Level,
  output logic [NUM_CH-1:0] Press,
  output logic [NUM_CH-1:0] Release,
  output logic [NUM_CH-1:0] Held,
  output logic [NUM_CH-1:0] HoldPulse
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    input_conditioner_ch #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .HOLD_TICKS    (HOLD_TICKS)
    ) u_ch (
      .clk         (HCLK),
      .rst_n       (HRESETn),
      .tick_i      (Tick),
      .n_in_i      (nIn[i]),
      .level_o     (Level[i]),
      .press_o     (Press[i]),
      .release_o   (Release[i]),
      .held_o      (Held[i]),
      .hold_pulse_o(HoldPulse[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed and randomized checks of input_conditioner against a cycle-level behavioural model.
module tb_input_conditioner;

  localparam int NCH  = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic           HCLK;
  logic           HRESETn;
  logic           Tick;
  logic [NCH-1:0] nIn;
  logic [NCH-1:0] Level, Press, Release, Held, HoldPulse;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural reference state
  logic [NCH-1:0] hist[$];
  logic [NCH-1:0] m_lvl, m_held, e_press, e_rel, e_hp;
  int             m_run[NCH];
  int             m_hticks[NCH];

  input_conditioner #(
    .NUM_CH(NCH), .SYNC_STAGES(SYNC), .DEBOUNCE_TICKS(DEB), .HOLD_TICKS(HOLD)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .Tick(Tick), .nIn(nIn),
    .Level(Level), .Press(Press), .Release(Release), .Held(Held), .HoldPulse(HoldPulse)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist = {};
    for (int k = 0; k < SYNC; k++) hist.push_back('1);
    m_lvl = '1; m_held = '0; e_press = '0; e_rel = '0; e_hp = '0;
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0;
      m_hticks[i] = 0;
    end
  endtask

  // One clock edge: s is nIn as it was SYNC edges ago; pulses are the edges of level/held.
  task automatic model_edge(input logic [NCH-1:0] nin, input logic t);
    logic [NCH-1:0] s, old_l, old_h;
    s = hist.pop_front();
    hist.push_back(nin);
    old_l = m_lvl;
    old_h = m_held;
    for (int i = 0; i < NCH; i++) begin
      if (s[i] == m_lvl[i]) m_run[i] = 0;
      else if (t) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i] = s[i];
          m_run[i] = 0;
        end
      end
      if (!old_l[i] && !m_lvl[i] && t && m_hticks[i] < HOLD) m_hticks[i]++;
      if (m_lvl[i]) m_hticks[i] = 0;
      m_held[i] = !m_lvl[i] && (m_hticks[i] >= HOLD);
    end
    e_press = old_l & ~m_lvl;
    e_rel   = ~old_l & m_lvl;
    e_hp    = ~old_h & m_held;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".Level"},     32'(Level),     32'(m_lvl));
    check({tag, ".Press"},     32'(Press),     32'(e_press));
    check({tag, ".Release"},   32'(Release),   32'(e_rel));
    check({tag, ".Held"},      32'(Held),      32'(m_held));
    check({tag, ".HoldPulse"}, 32'(HoldPulse), 32'(e_hp));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".Level"},     32'(Level),     32'hF);
    check({tag, ".Press"},     32'(Press),     32'h0);
    check({tag, ".Release"},   32'(Release),   32'h0);
    check({tag, ".Held"},      32'(Held),      32'h0);
    check({tag, ".HoldPulse"}, 32'(HoldPulse), 32'h0);
  endtask

  task automatic cyc(input string tag, input logic [NCH-1:0] nin, input logic t);
    nIn  = nin;
    Tick = t;
    @(posedge HCLK);
    model_edge(nin, t);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [NCH-1:0] v;
    int ev_cyc, ev_cnt, hp_cyc, hp_cnt;
    logic prev_held;

    HRESETn = 1'b0; Tick = 1'b1; nIn = '1;
    model_reset();

    // Reset held while inputs toggle
    for (int k = 0; k < 4; k++) begin
      nIn = NCH'($urandom);
      @(posedge HCLK); #1;
      check_reset_vals("in_reset");
    end
    nIn = '1;
    HRESETn = 1'b1;
    model_reset();
    ev_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      cyc("post_reset", '1, 1'b1);
      if ((Press | Release | HoldPulse) != '0) ev_cnt++;
    end
    check("post_reset_no_pulse", 32'(ev_cnt), 32'd0);

    // Clean press on ch0; Press and HoldPulse timing, then release
    ev_cyc = -1; ev_cnt = 0; hp_cyc = -1; hp_cnt = 0;
    for (int k = 1; k <= 26; k++) begin
      cyc("press0", 4'b1110, 1'b1);
      if (Press[0]) begin ev_cyc = k; ev_cnt++; end
      if (HoldPulse[0]) begin hp_cyc = k; hp_cnt++; end
    end
    check("press0_cycle", 32'(ev_cyc), 32'd6);
    check("press0_count", 32'(ev_cnt), 32'd1);
    check("hold0_cycle",  32'(hp_cyc), 32'd14);
    check("hold0_count",  32'(hp_cnt), 32'd1);
    ev_cyc = -1; prev_held = Held[0];
    for (int k = 1; k <= 20 && ev_cyc < 0; k++) begin
      cyc("release0", 4'b1111, 1'b1);
      if (Release[0]) begin
        ev_cyc = k;
        check("release0_held_prev", 32'(prev_held), 32'd1);
        check("release0_held_now",  32'(Held[0]),   32'd0);
      end
      prev_held = Held[0];
    end
    check("release0_cycle", 32'(ev_cyc), 32'd6);

    // Glitch on ch1: 3 cycles rejected, 4 cycles accepted
    ev_cnt = 0;
    for (int k = 0; k < 3; k++) cyc("glitch3", 4'b1101, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cyc("glitch3_after", 4'b1111, 1'b1);
      if (Press[1]) ev_cnt++;
    end
    check("glitch3_no_press", 32'(ev_cnt), 32'd0);
    ev_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      cyc("glitch4", 4'b1101, 1'b1);
      if (Press[1]) ev_cnt++;
    end
    for (int k = 0; k < 12; k++) begin
      cyc("glitch4_after", 4'b1111, 1'b1);
      if (Press[1]) ev_cnt++;
    end
    check("glitch4_press", 32'(ev_cnt), 32'd1);

    // Tick every 4th cycle on ch2
    ev_cyc = -1;
    for (int k = 1; k <= 24; k++) begin
      cyc("tick_gate", 4'b1011, 1'((k % 4) == 0));
      if (Press[2] && ev_cyc < 0) ev_cyc = k;
    end
    check("tick_gate_cycle", 32'(ev_cyc), 32'd16);
    for (int k = 0; k < 10; k++) cyc("tick_gate_rel", 4'b1111, 1'b1);

    // Simultaneous press on ch0 and ch3
    ev_cyc = -1;
    for (int k = 1; k <= 8; k++) begin
      cyc("concurrent", 4'b0110, 1'b1);
      if (Press != '0 && ev_cyc < 0) begin
        ev_cyc = k;
        check("concurrent_mask", 32'(Press), 32'h9);
      end
    end
    check("concurrent_cycle", 32'(ev_cyc), 32'd6);

    // Reset mid-debounce of the release
    for (int k = 0; k < 4; k++) cyc("mid_deb", 4'b1111, 1'b1);
    HRESETn = 1'b0;
    #1;
    check_reset_vals("async_reset");
    model_reset();
    @(posedge HCLK); #1;
    check_reset_vals("async_reset_hold");
    HRESETn = 1'b1;
    ev_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      cyc("after_reset", 4'b1111, 1'b1);
      if ((Press | Release) != '0) ev_cnt++;
    end
    check("after_reset_no_pulse", 32'(ev_cnt), 32'd0);

    // Randomized: slowly changing inputs with sparse Tick
    v = '1;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 11) == 0) v[i] = ~v[i];
      cyc("random", v, 1'($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
